// File: rtl/unary_collect_9_if.sv
// Port bundle between the unary adder drain side and the collector.
// With UNARY_COLLECT_SAT_EN defined the bundle also carries sat_err.
interface unary_collect_9_if #(parameter int WIDTH = 9);
   logic             en;
   logic             phase;
   logic             din;
   logic             carry_in;
   logic             ready;
   logic [WIDTH-1:0] sum_out;
   logic             ovf_out;
   logic             valid;
   logic             overrun;
`ifdef UNARY_COLLECT_SAT_EN
   logic             sat_err;

   modport master (output en, phase, din, carry_in, ready,
                   input  sum_out, ovf_out, valid, overrun, sat_err);
   modport slave  (input  en, phase, din, carry_in, ready,
                   output sum_out, ovf_out, valid, overrun, sat_err);
`else
   modport master (output en, phase, din, carry_in, ready,
                   input  sum_out, ovf_out, valid, overrun);
   modport slave  (input  en, phase, din, carry_in, ready,
                   output sum_out, ovf_out, valid, overrun);
`endif
endinterface

// File: rtl/unary_collect_9.sv
// Counts the unary adder's drain-phase pulse train back into a binary sum.
// Macro UNARY_COLLECT_SAT_EN: saturating counter and sticky sat_err output.
module unary_collect_9 #(
   parameter int WIDTH = 9
) (
   input logic            clk,
   input logic            rst,
   unary_collect_9_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ARM, COLLECT, WAIT} state_t;

   state_t           state;
   logic [WIDTH-1:0] cnt;
   logic             ovf_acc;
   logic             term;
   logic             slot_free;
   logic             load;
   logic             cnt_full;

   function automatic logic [WIDTH-1:0] next_count(input logic [WIDTH-1:0] c);
`ifdef UNARY_COLLECT_SAT_EN
      return (&c) ? c : c + WIDTH'(1);
`else
      return c + WIDTH'(1);
`endif
   endfunction

   always_comb begin
      term      = 1'b0;
      slot_free = 1'b0;
      load      = 1'b0;
      cnt_full  = 1'b0;
      term      = bus.en && (state == COLLECT) && (!bus.phase || !bus.din);
      slot_free = !bus.valid || bus.ready;
      load      = term && slot_free;
      cnt_full  = &cnt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         ovf_acc     <= 1'b0;
         bus.sum_out <= '0;
         bus.ovf_out <= 1'b0;
         bus.valid   <= 1'b0;
         bus.overrun <= 1'b0;
`ifdef UNARY_COLLECT_SAT_EN
         bus.sat_err <= 1'b0;
`endif
      end else begin
         // Output slot runs regardless of en; a fresh load beats the consume.
         if (load) begin
            bus.sum_out <= cnt;
            bus.ovf_out <= ovf_acc;
            bus.valid   <= 1'b1;
         end else if (bus.valid && bus.ready) begin
            bus.valid   <= 1'b0;
         end
         if (term && !slot_free)
            bus.overrun <= 1'b1;

         if (bus.en) begin
            case (state)
               IDLE: begin
                  ovf_acc <= ovf_acc | bus.carry_in;
                  if (bus.phase) begin
                     cnt   <= '0;
                     state <= ARM;
                  end
               end
               // Adder carry lags a cycle and din still shows accumulate data.
               ARM: begin
                  ovf_acc <= ovf_acc | bus.carry_in;
                  state   <= COLLECT;
               end
               COLLECT: begin
                  if (!bus.phase) begin
                     ovf_acc <= 1'b0;
                     state   <= IDLE;
                  end else if (!bus.din) begin
                     ovf_acc <= 1'b0;
                     state   <= WAIT;
                  end else begin
                     cnt <= next_count(cnt);
`ifdef UNARY_COLLECT_SAT_EN
                     if (cnt_full)
                        bus.sat_err <= 1'b1;
`endif
                  end
               end
               WAIT: begin
                  if (!bus.phase)
                     state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
